usbf_sie_tx_gen: RTL and testbench

USBF_SIE_TX_GEN -- requirements
Module: usbf_sie_tx_gen

---
 rtl/usbf_sie_tx_gen.sv | 147 ++++++++++++++
 tb/tb_usbf_sie_tx_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbf_sie_tx_gen.sv
// usbf_sie_tx_gen: USB SIE transmit generator driving a UTMI PHY with PID, data + CRC16,
// token + CRC5 (host mode) and chirp K; an inter-packet gap follows every packet.
module usbf_sie_tx_gen #(
    parameter int IPG_CYCLES = 4,
    parameter bit TOKEN_EN   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        chirp_i,
    input  logic        utmi_txready_i,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_pid_i,
    input  logic [10:0] tx_token_i,
    input  logic        data_valid_i,
    input  logic        data_strb_i,
    input  logic [7:0]  data_i,
    input  logic        data_last_i,
    output logic [7:0]  utmi_data_o,
    output logic        utmi_txvalid_o,
    output logic        tx_accept_o,
    output logic        data_accept_o,
    output logic        tx_busy_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_PID, S_DATA, S_CRC1, S_CRC2, S_TOK1, S_TOK2, S_DONE, S_GAP, S_CHIRP
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(IPG_CYCLES - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_pid;
    logic        r_is_data, r_is_tok, r_zlp;
    logic [10:0] r_token;
    logic [15:0] r_crc, w_crc_next;
    logic [7:0]  r_gap;
    logic [4:0]  w_crc5;
    logic        w_abort, w_take, w_pid_data, w_pid_tok;

    assign w_abort    = !enable_i && !chirp_i;
    assign w_take     = r_state == S_IDLE && !chirp_i && tx_valid_i;
    assign w_pid_data = tx_pid_i inside {8'hC3, 8'h4B, 8'h87, 8'h0F};
    assign w_pid_tok  = TOKEN_EN && (tx_pid_i inside {8'hE1, 8'h69, 8'hA5, 8'h2D});
    assign tx_accept_o = r_state == S_IDLE;
    assign tx_busy_o   = r_state != S_IDLE;

    // Reflected CRC16 (0xA001), one byte per accepted data beat
    always_comb begin
        w_crc_next = r_crc ^ {8'h00, data_i};
        for (int k = 0; k < 8; k++)
            w_crc_next = w_crc_next[0] ? (w_crc_next >> 1) ^ 16'hA001 : w_crc_next >> 1;
    end

    // CRC5 shift register fed token LSB first
    always_comb begin
        w_crc5 = 5'h1F;
        for (int k = 0; k < 11; k++)
            w_crc5 = {w_crc5[3:0], 1'b0} ^ ((r_token[k] ^ w_crc5[4]) ? 5'h05 : 5'h00);
    end

    always_comb begin
        w_next         = r_state;
        utmi_data_o    = 8'h00;
        utmi_txvalid_o = 1'b0;
        data_accept_o  = 1'b0;
        case (r_state)
            S_IDLE: w_next = chirp_i ? S_CHIRP : tx_valid_i ? S_PID : S_IDLE;
            S_PID: begin
                utmi_data_o    = r_pid;
                utmi_txvalid_o = 1'b1;
                data_accept_o  = r_zlp && utmi_txready_i;
                if (utmi_txready_i)
                    w_next = r_zlp ? S_CRC1 : r_is_data ? S_DATA : r_is_tok ? S_TOK1 : S_DONE;
            end
            S_DATA: begin
                utmi_data_o    = data_i;
                utmi_txvalid_o = data_valid_i;
                data_accept_o  = utmi_txready_i;
                if (utmi_txready_i && data_last_i) w_next = S_CRC1;
            end
            S_CRC1: begin
                utmi_data_o    = ~r_crc[7:0];
                utmi_txvalid_o = 1'b1;
                if (utmi_txready_i) w_next = S_CRC2;
            end
            S_CRC2: begin
                utmi_data_o    = ~r_crc[15:8];
                utmi_txvalid_o = 1'b1;
                if (utmi_txready_i) w_next = S_DONE;
            end
            S_TOK1: begin
                utmi_data_o    = r_token[7:0];
                utmi_txvalid_o = 1'b1;
                if (utmi_txready_i) w_next = S_TOK2;
            end
            S_TOK2: begin
                utmi_data_o    = {~w_crc5, r_token[10:8]};
                utmi_txvalid_o = 1'b1;
                if (utmi_txready_i) w_next = S_DONE;
            end
            S_DONE: w_next = IPG_CYCLES > 0 ? S_GAP : S_IDLE;
            S_GAP:  w_next = r_gap == 8'h00 ? S_IDLE : S_GAP;
            S_CHIRP: begin
                utmi_txvalid_o = 1'b1;
                if (!chirp_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_pid     <= 8'h00;
            r_is_data <= 1'b0;
            r_is_tok  <= 1'b0;
            r_zlp     <= 1'b0;
            r_token   <= 11'h000;
            r_crc     <= 16'hFFFF;
            r_gap     <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_abort) begin
                r_pid     <= 8'h00;
                r_is_data <= 1'b0;
                r_is_tok  <= 1'b0;
                r_zlp     <= 1'b0;
                r_token   <= 11'h000;
                r_crc     <= 16'hFFFF;
                r_gap     <= 8'h00;
            end else begin
                if (w_take) begin
                    r_pid     <= tx_pid_i;
                    r_is_data <= w_pid_data;
                    r_is_tok  <= w_pid_tok;
                    r_zlp     <= w_pid_data && data_valid_i && !data_strb_i && data_last_i;
                    r_token   <= tx_token_i;
                end
                r_crc <= r_state == S_IDLE ? 16'hFFFF :
                         (r_state == S_DATA && data_valid_i && utmi_txready_i) ? w_crc_next : r_crc;
                r_gap <= r_state == S_DONE ? GAP_LOAD :
                         (r_state == S_GAP && r_gap != 8'h00) ? r_gap - 8'h01 : r_gap;
            end
        end
    end
endmodule

// File: tb/tb_usbf_sie_tx_gen.sv
// tb_usbf_sie_tx_gen: randomized bench; expected byte stream per packet comes from a
// byte-level model (forward CRC16/CRC5 formulations) and is checked cycle by cycle.
module tb_usbf_sie_tx_gen;
    localparam int IPG = 4;

    logic        clk = 1'b0, rst_i = 1'b0;
    logic        enable_i = 1'b1, chirp_i = 1'b0, utmi_txready_i = 1'b1, tx_valid_i = 1'b0;
    logic [7:0]  tx_pid_i = 8'h00;
    logic [10:0] tx_token_i = 11'h000;
    logic        data_valid_i = 1'b0, data_strb_i = 1'b1, data_last_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  utmi_data_o;
    logic        utmi_txvalid_o, tx_accept_o, data_accept_o, tx_busy_o;

    int          checks = 0, failures = 0;
    logic [7:0]  exp_q[$], got_q[$], src_buf[$], w[$], pl[$];
    int          src_idx = 0, stall_pct = 0, post = 0, dacc_cnt = 0;
    logic        src_on = 1'b0, src_zlp = 1'b0, run = 1'b0, dacc = 1'b0;
    logic        prev_chirp = 1'b0, prev_abort = 1'b0, prev_norm = 1'b0, prev_txv = 1'b0, prev_rdy = 1'b0;
    logic [7:0]  prev_data = 8'h00, e;
    logic [7:0]  pids [14] = '{8'hC3, 8'h4B, 8'h87, 8'h0F, 8'hE1, 8'h69, 8'hA5, 8'h2D,
                               8'hD2, 8'h5A, 8'h1E, 8'h96, 8'h3C, 8'hB4};

    usbf_sie_tx_gen #(.IPG_CYCLES(IPG), .TOKEN_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .chirp_i(chirp_i),
        .utmi_txready_i(utmi_txready_i), .tx_valid_i(tx_valid_i), .tx_pid_i(tx_pid_i),
        .tx_token_i(tx_token_i), .data_valid_i(data_valid_i), .data_strb_i(data_strb_i),
        .data_i(data_i), .data_last_i(data_last_i), .utmi_data_o(utmi_data_o),
        .utmi_txvalid_o(utmi_txvalid_o), .tx_accept_o(tx_accept_o),
        .data_accept_o(data_accept_o), .tx_busy_o(tx_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_data(input logic [7:0] p);
        return p inside {8'hC3, 8'h4B, 8'h87, 8'h0F};
    endfunction

    function automatic logic is_tok(input logic [7:0] p);
        return p inside {8'hE1, 8'h69, 8'hA5, 8'h2D};
    endfunction

    // Forward (MSB-register) CRC16 over bits LSB-first, reflected at the end
    function automatic logic [15:0] crc16_model(input logic [7:0] b[$]);
        logic [15:0] c, r;
        c = 16'hFFFF;
        foreach (b[i])
            for (int j = 0; j < 8; j++)
                c = {c[14:0], 1'b0} ^ ((b[i][j] ^ c[15]) ? 16'h8005 : 16'h0000);
        for (int j = 0; j < 16; j++) r[j] = c[15 - j];
        return ~r;
    endfunction

    // Reflected CRC5 (0x14), un-reflected to the transmitted field
    function automatic logic [4:0] crc5_field(input logic [10:0] t);
        logic [4:0] r, f;
        r = 5'h1F;
        for (int j = 0; j < 11; j++) r = (r[0] ^ t[j]) ? (r >> 1) ^ 5'h14 : r >> 1;
        for (int j = 0; j < 5; j++) f[j] = r[4 - j];
        return ~f;
    endfunction

    function automatic void build(input logic [7:0] pid, input logic [10:0] tok);
        logic [15:0] c;
        exp_q.push_back(pid);
        if (is_data(pid)) begin
            c = crc16_model(src_buf);
            foreach (src_buf[i]) exp_q.push_back(src_buf[i]);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end else if (is_tok(pid)) begin
            exp_q.push_back(tok[7:0]);
            exp_q.push_back({crc5_field(tok), tok[10:8]});
        end
    endfunction

    function automatic void drive_src();
        data_valid_i = src_on && (src_zlp || src_idx < src_buf.size());
        data_strb_i  = !src_zlp;
        data_last_i  = src_zlp || (src_idx == src_buf.size() - 1);
        data_i       = 8'h00;
        if (src_on && src_idx < src_buf.size()) data_i = src_buf[src_idx];
    endfunction

    task automatic tick();
        @(negedge clk);
        dacc = data_accept_o;
        @(posedge clk);
        #1;
        if (dacc) begin
            if (src_zlp) src_zlp = 1'b0;
            else src_idx++;
        end
        drive_src();
        utmi_txready_i = ($urandom_range(0, 99) >= stall_pct);
    endtask

    task automatic start_pkt(input logic [7:0] pid, input logic [10:0] tok, input logic [7:0] p[$], input int stall);
        int n = 0;
        while (!tx_accept_o && n < 200) begin tick(); n++; end
        chk("idle_before_req", tx_accept_o, 1);
        got_q.delete();
        dacc_cnt = 0;
        src_buf = p;
        src_idx = 0;
        src_on  = is_data(pid);
        src_zlp = is_data(pid) && p.size() == 0;
        drive_src();
        stall_pct  = stall;
        tx_valid_i = 1'b1;
        tx_pid_i   = pid;
        tx_token_i = tok;
        tick();
        tx_valid_i = 1'b0;
        chk("req_taken", tx_busy_o, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !tx_accept_o) && n < 2000) begin tick(); n++; end
        chk("pkt_done_in_time", n < 2000, 1);
    endtask

    task automatic chk_got(input string name, input logic [7:0] x[$]);
        chk({name, "_len"}, got_q.size(), x.size());
        foreach (x[i]) if (i < got_q.size()) chk(name, got_q[i], x[i]);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("busy_vs_accept", tx_busy_o, !tx_accept_o);
            if (prev_chirp) begin
                chk("chirp_txvalid", utmi_txvalid_o, 1);
                chk("chirp_data", utmi_data_o, 8'h00);
            end else if (prev_abort) begin
                chk("abort_accept", tx_accept_o, 1);
                chk("abort_txvalid", utmi_txvalid_o, 0);
            end else if (enable_i || chirp_i) begin
                if (prev_norm && prev_txv && !prev_rdy) begin
                    chk("stall_txvalid", utmi_txvalid_o, 1);
                    chk("stall_data", utmi_data_o, prev_data);
                end
                if (post > 0) begin
                    if (post <= IPG + 1) begin
                        chk("gap_accept", tx_accept_o, 0);
                        chk("gap_txvalid", utmi_txvalid_o, 0);
                        post++;
                    end else begin
                        chk("gap_end_accept", tx_accept_o, 1);
                        post = 0;
                    end
                end
                if (utmi_txvalid_o && exp_q.size() == 0) begin
                    chk("txvalid_unexpected", utmi_txvalid_o, 0);
                end else if (utmi_txvalid_o && utmi_txready_i) begin
                    e = exp_q.pop_front();
                    got_q.push_back(utmi_data_o);
                    chk("tx_byte", utmi_data_o, e);
                    if (exp_q.size() == 0) post = 1;
                end
            end
            if (tx_valid_i && tx_accept_o && enable_i && !chirp_i) build(tx_pid_i, tx_token_i);
            if (data_accept_o) begin
                chk("data_accept_has_src", data_valid_i, 1);
                dacc_cnt++;
            end
            if (!enable_i && !chirp_i) begin
                exp_q.delete();
                post = 0;
            end
            prev_norm  = !prev_chirp && !prev_abort && (enable_i || chirp_i);
            prev_abort = !enable_i && !chirp_i;
            prev_chirp = chirp_i;
            prev_txv   = utmi_txvalid_o;
            prev_rdy   = utmi_txready_i;
            prev_data  = utmi_data_o;
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_i = 1'b1;
        #3;
        chk("rst_data", utmi_data_o, 8'h00);
        chk("rst_txvalid", utmi_txvalid_o, 0);
        chk("rst_data_accept", data_accept_o, 0);
        chk("rst_busy", tx_busy_o, 0);
        chk("rst_accept", tx_accept_o, 1);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        run = 1'b1;

        pl.delete();
        start_pkt(8'hD2, 11'h000, pl, 0);
        wait_done();
        w = '{8'hD2};
        chk_got("ack", w);

        start_pkt(8'hC3, 11'h000, pl, 0);
        wait_done();
        w = '{8'hC3, 8'h00, 8'h00};
        chk_got("zlp", w);
        chk("zlp_data_accepts", dacc_cnt, 1);

        start_pkt(8'h2D, 11'h715, pl, 0);
        wait_done();
        w = '{8'h2D, 8'h15, 8'hBF};
        chk_got("setup_token", w);

        for (int i = 1; i <= 9; i++) pl.push_back(8'(8'h30 + i));
        start_pkt(8'hC3, 11'h000, pl, 0);
        wait_done();
        w = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        chk_got("data_check_str", w);
        chk("data_check_accepts", dacc_cnt, 9);

        pl = '{8'h00, 8'h01, 8'h02, 8'h03};
        start_pkt(8'h4B, 11'h000, pl, 40);
        wait_done();
        chk("data1_stall_len", got_q.size(), 7);

        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
        start_pkt(8'h87, 11'h000, pl, 0);
        for (int n = 0; n < 100 && got_q.size() < 4; n++) tick();
        enable_i = 1'b0;
        utmi_txready_i = 1'b0;
        stall_pct = 100;
        tick();
        src_on = 1'b0;
        drive_src();
        enable_i = 1'b1;
        stall_pct = 0;
        repeat (3) tick();
        chk("abort_no_crc", got_q.size(), 4);

        chirp_i = 1'b1;
        repeat (6) tick();
        chirp_i = 1'b0;
        repeat (3) tick();

        for (int n = 0; n < 40; n++) begin
            logic [7:0] pid;
            int len;
            pid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pids[$urandom_range(0, 13)];
            len = $urandom_range(0, 6);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            start_pkt(pid, 11'($urandom), pl, $urandom_range(0, 60));
            wait_done();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
